// File: rtl/mmv_ram_responder_if.sv
// mmv master/slave bus bundle: request lines toward the responder, read data,
// valid and busy back toward the master.
interface mmv_ram_responder_if #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 8
);
  logic [AWIDTH-1:0] s_addr;
  logic              s_wreq;
  logic [DWIDTH-1:0] s_wdat;
  logic              s_rreq;
  logic [DWIDTH-1:0] s_rdat;
  logic              s_rval;
  logic              s_busy;

  modport master (
    output s_addr, s_wreq, s_wdat, s_rreq,
    input  s_rdat, s_rval, s_busy
  );

  modport slave (
    input  s_addr, s_wreq, s_wdat, s_rreq,
    output s_rdat, s_rval, s_busy
  );
endinterface

// File: rtl/mmv_ram_responder.sv
// mmv RAM responder: 2^AWIDTH x DWIDTH scratch RAM with a fixed RDDELAY read
// latency and at most MAXPEND reads in flight. s_busy stalls reads and writes
// alike; a simultaneous read and write to one address returns the old word.
module mmv_ram_responder #(
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 8,
  parameter int RDDELAY = 4,
  parameter int MAXPEND = 4
) (
  input  logic                clk,
  input  logic                reset,
  mmv_ram_responder_if.slave  s
);

  localparam int CW    = $clog2(MAXPEND + 1);
  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] r_mem [0:DEPTH-1];
  logic              r_vld [0:RDDELAY-1];
  logic [DWIDTH-1:0] r_dat [0:RDDELAY-1];
  logic [CW-1:0]     r_cnt;
  logic              r_busy;

  logic              w_acc_rd;
  logic              w_acc_wr;
  logic              w_retire;
  logic [CW-1:0]     w_cnt_next;

  // Requests are only taken while the registered busy flag is low.
  assign w_acc_rd = s.s_rreq & ~r_busy;
  assign w_acc_wr = s.s_wreq & ~r_busy;
  assign w_retire = r_vld[RDDELAY-1];

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_acc_wr) begin
      r_mem[s.s_addr] <= s.s_wdat;
    end
  end

  // Pipeline head: sample the RAM on acceptance (old data wins over a same-edge write).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld[0] <= 1'b0;
      r_dat[0] <= '0;
    end else begin
      r_vld[0] <= w_acc_rd;
      if (w_acc_rd) begin
        r_dat[0] <= r_mem[s.s_addr];
      end
    end
  end

  // Remaining delay stages shift valid and data together every clock.
  generate
    for (genvar gi = 1; gi < RDDELAY; gi++) begin : g_stage
      // Stage gi copies stage gi-1; reset drops anything in flight.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_vld[gi] <= 1'b0;
          r_dat[gi] <= '0;
        end else begin
          r_vld[gi] <= r_vld[gi-1];
          r_dat[gi] <= r_dat[gi-1];
        end
      end
    end
  endgenerate

  // Outstanding-read count: up on acceptance, down when a response is presented.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_acc_rd && !w_retire) begin
      w_cnt_next = r_cnt + CW'(1);
    end else if (!w_acc_rd && w_retire) begin
      w_cnt_next = r_cnt - CW'(1);
    end
  end

  // Busy is registered from the next count, so it releases one edge after a retire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_busy <= (w_cnt_next == CW'(MAXPEND));
    end
  end

  assign s.s_rval = r_vld[RDDELAY-1];
  assign s.s_rdat = r_dat[RDDELAY-1];
  assign s.s_busy = r_busy;

endmodule

// File: tb/tb_mmv_ram_responder.sv
// Bench for mmv_ram_responder: directed steps followed by random traffic,
// checked cycle by cycle against a queue-based model of responses in flight.
module tb_mmv_ram_responder;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int RD = 16;
  localparam int MP = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  mmv_ram_responder_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  mmv_ram_responder #(
    .AWIDTH(AW), .DWIDTH(DW), .RDDELAY(RD), .MAXPEND(MP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .s     (bus.slave)
  );

  typedef struct packed {
    int          due;   // edge index after which the response is visible
    logic [7:0]  dat;
  } rsp_t;

  logic [DW-1:0] m_mem [0:(1<<AW)-1];
  rsp_t          m_q[$];
  logic          m_busy = 1'b0;
  logic          m_acc  = 1'b0;
  int            cyc    = 0;
  int            n_pass = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive the request, advance the model at the edge, check 1 time unit later.
  task automatic step(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
    rsp_t e;
    logic exp_rval;
    bus.s_wreq = w;
    bus.s_rreq = r;
    bus.s_addr = a;
    bus.s_wdat = d;
    @(posedge clk);
    cyc++;
    m_acc = (w | r) & ~m_busy;
    if (m_acc && r) begin
      e.due = cyc + RD - 1;
      e.dat = m_mem[a];
      m_q.push_back(e);
    end
    if (m_acc && w) m_mem[a] = d;
    while (m_q.size() > 0 && m_q[0].due < cyc) void'(m_q.pop_front());
    m_busy   = (m_q.size() == MP);
    exp_rval = (m_q.size() > 0 && m_q[0].due == cyc);
    #1;
    chk("busy", bus.s_busy, m_busy);
    chk("rval", bus.s_rval, exp_rval);
    if (exp_rval) chk("rdat", bus.s_rdat, m_q[0].dat);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Read held until accepted, as a master must do while busy is high.
  task automatic read_held(input logic [7:0] a);
    int guard;
    guard = 0;
    do begin
      step(1'b0, 1'b1, a, 8'h00);
      guard++;
    end while (!m_acc && guard < 64);
  endtask

  // Asynchronous reset raised mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_rval", bus.s_rval, 1'b0);
    chk("rst_rdat", bus.s_rdat, 8'h00);
    chk("rst_busy", bus.s_busy, 1'b0);
    m_q.delete();
    m_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bus.s_wreq = 1'b0;
    bus.s_rreq = 1'b0;
    bus.s_addr = '0;
    bus.s_wdat = '0;

    // Reset state
    @(negedge clk);
    chk("init_rval", bus.s_rval, 1'b0);
    chk("init_rdat", bus.s_rdat, 8'h00);
    chk("init_busy", bus.s_busy, 1'b0);
    reset = 1'b0;

    // First edge after release accepts a write
    step(1'b1, 1'b0, 8'h10, 8'hA5);

    // Preload every other address
    for (int i = 0; i < 256; i++) begin
      if (i == 8'h10) continue;
      if (i < 10)            step(1'b1, 1'b0, 8'(i), 8'(i) ^ 8'hFF);
      else if (i == 8'h20)   step(1'b1, 1'b0, 8'(i), 8'h55);
      else                   step(1'b1, 1'b0, 8'(i), 8'($urandom));
    end

    // Read back the first-edge write
    read_held(8'h10);
    idle(RD + 2);

    // Write then read, single pulse at nominal latency
    step(1'b1, 1'b0, 8'h7F, 8'h3C);
    read_held(8'h7F);
    idle(RD + 2);

    // Backpressure: ten held reads over addresses 0..9
    for (int i = 0; i < 10; i++) read_held(8'(i));
    idle(RD + 4);

    // Simultaneous read and write: old data out, new data stored
    step(1'b1, 1'b1, 8'h20, 8'hAA);
    idle(RD + 2);
    read_held(8'h20);
    idle(RD + 2);

    // Reset while idle with nonzero read data on the bus
    do_reset();

    // Reset with reads in flight: none may return
    for (int i = 0; i < 3; i++) read_held(8'(i));
    idle(2);
    do_reset();
    idle(RD + 4);
    read_held(8'h7F);
    idle(RD + 2);

    // Random mixed traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
           8'($urandom), 8'($urandom));
    end
    idle(RD + 4);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule

// File: doc/mmv_ram_responder.md
# mmv_ram_responder

Synthesizable MemoryMapped slave containing a 2^AWIDTH x DWIDTH RAM, with fixed read latency and a bounded number of outstanding reads. It is the responder end of the mmv master/slave interface driven by the mmv RAM testers. It serves as the reference target in tester benches and as an on-chip scratch RAM behind any mmv master. Accepted reads return data exactly RDDELAY cycles after acceptance. s_busy throttles the master once MAXPEND reads are in flight.

## Interface
- AWIDTH, 8, address width; RAM depth = 2^AWIDTH words
- DWIDTH, 8, data width
- RDDELAY, 4, read latency in clocks, RDDELAY >= 1
- MAXPEND, 4, max outstanding reads, 1 <= MAXPEND <= RDDELAY
- reset  in  1  asynchronous reset, active high
- clk  in  1  single clock; all logic on rising edge
- s_addr  in  AWIDTH  word address for the current request
- s_wreq  in  1  write request
- s_wdat  in  DWIDTH  write data
- s_rreq  in  1  read request
- s_rdat  out  DWIDTH  read data, valid while s_rval = 1
- s_rval  out  1  read data valid, one-cycle pulse per accepted read
- s_busy  out  1  request not accepted this cycle; master must hold its request

## Operation
- Acceptance: a request is accepted at a rising edge where (s_wreq | s_rreq) = 1 and s_busy = 0. When s_busy = 1, the block ignores s_addr, s_wdat and the request lines.
- Write: the accepted write stores s_wdat at s_addr on that edge. There is no response.
- Read: the accepted read samples RAM[s_addr] on that edge, then pushes the word through an RDDELAY-stage valid/data pipeline.
- Simultaneous s_wreq and s_rreq: both are accepted at the same address. Ordering is read-before-write: the read returns the old contents and the write lands on the same edge.
- Outstanding counter cnt, width clog2(MAXPEND+1):
  - +1 on an accepted read.
  - -1 on an edge where s_rval = 1.
  - Both events on the same edge: cnt unchanged.
- s_busy is a register loaded each edge with (cnt_next == MAXPEND). It is conservative: s_busy stays 1 in a cycle where a read retires, and releases on the following edge.
- s_busy blocks writes as well as reads. The whole interface stalls together.
- RAM contents are not affected by reset and are undefined after power-up.
- Address range: every AWIDTH-bit address is valid; there is no decode error.

## Timing
- Reset (asynchronous, on assertion):
  - s_rval = 0, s_rdat = 0, s_busy = 0, cnt = 0, all pipeline valid bits = 0.
  - Pipeline data registers are cleared to 0.
  - Reads in flight are discarded and never returned, even after reset deasserts.
- Release: the first request can be accepted at the first rising edge after reset deasserts.
- Read latency: for a read accepted at edge n, s_rval = 1 in the cycle after edge n+RDDELAY-1, so the master samples it at edge n+RDDELAY.
  - RDDELAY = 1 gives data in the cycle directly after acceptance.
- Throughput:
  - With MAXPEND = RDDELAY, back-to-back reads run at one per clock except for a single stall cycle each time cnt reaches MAXPEND.
  - Writes alone never set s_busy.
- Ordering: read responses return in acceptance order, one per cycle at most. There are no bubbles other than those in the request stream.
- Write-then-read to the same address on consecutive accepted edges returns the new data.

## Test plan
- Reset checks:
  - Assert reset mid-idle: s_rval = 0, s_rdat = 0, s_busy = 0 immediately, with no clock needed.
  - Deassert, then write 0xA5 to 0x10 on the first edge. It is accepted with no stall.
- Write/read latency: RDDELAY = 16, MAXPEND = 4.
  - Write 0x3C to 0x7F, then read 0x7F.
  - Required: s_rval single pulse exactly 16 edges after read acceptance, s_rdat = 0x3C.
- Backpressure:
  - Hold s_rreq = 1 for 10 cycles over addresses 0..9, preloaded with data = address ^ 0xFF, RDDELAY = 16, MAXPEND = 4.
  - Required: s_busy rises after the 4th acceptance and falls only after retirements. cnt never exceeds 4. Data returns in order as 0xFF, 0xFE, ... 0xF6.
- Simultaneous read and write:
  - Preload 0x55 at 0x20.
  - In one cycle assert s_wreq (data 0xAA) and s_rreq, both at 0x20.
  - Required: the response is 0x55. A later read of 0x20 returns 0xAA.
- Reset mid-operation:
  - Issue 3 reads, assert reset 2 cycles later, release.
  - Required: no s_rval pulse from the discarded reads.
  - A new read after release returns its data with nominal latency.
- Address-bus sweep with the mmv RAM address-bus tester as master, no faults injected:
  - Required: the tester reports done with no fault pulse.
  - With address bit 6 shorted to bit 5 between master and responder, the tester reports fault.
